// File: rtl/trace_error_logger_if.sv
// Error-record stream from trace_error_logger to the reporting logic.
// master drives valid + record fields, slave returns ready.
interface trace_error_logger_if #(
  parameter int IDX_W = 16
) ();
  logic             rec_valid;
  logic             rec_ready;
  logic [IDX_W-1:0] rec_index;
  logic [1:0]       rec_type;
  logic [3:0]       rec_code;

  modport master (
    output rec_valid,
    output rec_index,
    output rec_type,
    output rec_code,
    input  rec_ready
  );

  modport slave (
    input  rec_valid,
    input  rec_index,
    input  rec_type,
    input  rec_code,
    output rec_ready
  );
endinterface

// File: rtl/trace_error_logger.sv
// Trace-checker statistics (saturating counters) + FIFO of error records.
// Ports: clk, reset, format_type, error_code in; reg/mem/err_cnt,
// fifo_count, overflow out; rec (master) carries the record stream.
module trace_error_logger #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           format_type,
  input  logic [3:0]           error_code,
  output logic [15:0]          reg_cnt,
  output logic [15:0]          mem_cnt,
  output logic [15:0]          err_cnt,
  trace_error_logger_if.master rec,
  output logic [CNT_W-1:0]     fifo_count,
  output logic                 overflow
);

  localparam logic [15:0] SAT = 16'hFFFF;

  logic [IDX_W-1:0] idx_q  [DEPTH];
  logic [1:0]       type_q [DEPTH];
  logic [3:0]       code_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [IDX_W-1:0] line_idx;

  logic is_reg;
  logic is_mem;
  logic line_vld;
  logic line_err;
  logic full;
  logic pop;
  logic push;

  always_comb begin
    is_reg = 1'b0;
    is_mem = 1'b0;
    unique case (1'b1)
      format_type == 2'b01: is_reg = 1'b1;
      format_type == 2'b10: is_mem = 1'b1;
      default: ;
    endcase
  end

  assign line_vld = is_reg | is_mem;
  assign line_err = line_vld & (error_code != 4'h0);
  assign full     = fifo_count == CNT_W'(DEPTH);
  assign pop      = rec.rec_valid & rec.rec_ready;
  // A full FIFO still accepts when its head leaves on the same edge.
  assign push     = line_err & (~full | pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_cnt  <= '0;
      mem_cnt  <= '0;
      err_cnt  <= '0;
      line_idx <= '0;
      overflow <= 1'b0;
    end else begin
      if (is_reg && reg_cnt != SAT)
        reg_cnt <= reg_cnt + 16'd1;
      if (is_mem && mem_cnt != SAT)
        mem_cnt <= mem_cnt + 16'd1;
      if (line_err && err_cnt != SAT)
        err_cnt <= err_cnt + 16'd1;
      if (line_vld)
        line_idx <= line_idx + IDX_W'(1);
      if (line_err && !push)
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        idx_q[i]  <= '0;
        type_q[i] <= '0;
        code_q[i] <= '0;
      end
    end else begin
      if (push) begin
        idx_q[wr_ptr]  <= line_idx;
        type_q[wr_ptr] <= format_type;
        code_q[wr_ptr] <= error_code;
        wr_ptr         <= wr_ptr + PTR_W'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign rec.rec_valid = fifo_count != '0;
  assign rec.rec_index = idx_q[rd_ptr];
  assign rec.rec_type  = type_q[rd_ptr];
  assign rec.rec_code  = code_q[rd_ptr];

endmodule

// File: tb/tb_trace_error_logger.sv
// Bench for trace_error_logger: directed scenarios plus random traffic
// checked against a queue-based behavioural model.
module tb_trace_error_logger;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [15:0] idx;
    logic [1:0]  ty;
    logic [3:0]  code;
  } rec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  format_type = '0;
  logic [3:0]  error_code = '0;
  logic [15:0] reg_cnt, mem_cnt, err_cnt;
  logic [2:0]  fifo_count;
  logic        overflow;

  trace_error_logger_if #(.IDX_W(16)) rif ();

  trace_error_logger #(.DEPTH(DEPTH), .IDX_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .format_type (format_type),
    .error_code  (error_code),
    .reg_cnt     (reg_cnt),
    .mem_cnt     (mem_cnt),
    .err_cnt     (err_cnt),
    .rec         (rif),
    .fifo_count  (fifo_count),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_mis = 0;
  int   m_reg, m_mem, m_err, m_idx;
  bit   m_ovf;
  rec_t q[$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_reg = 0; m_mem = 0; m_err = 0; m_idx = 0; m_ovf = 0;
    q.delete();
  endtask

  task automatic model_step(logic [1:0] ft, logic [3:0] ec, logic rdy);
    bit vld, er, pop;
    rec_t r;
    vld = (ft == 2'b01) || (ft == 2'b10);
    er  = vld && (ec != 4'h0);
    pop = (q.size() > 0) && rdy;
    if (pop) void'(q.pop_front());
    if (ft == 2'b01 && m_reg < 65535) m_reg++;
    if (ft == 2'b10 && m_mem < 65535) m_mem++;
    if (er) begin
      if (m_err < 65535) m_err++;
      r.idx = 16'(m_idx); r.ty = ft; r.code = ec;
      if (q.size() < DEPTH) q.push_back(r);
      else m_ovf = 1;
    end
    if (vld) m_idx = (m_idx + 1) % 65536;
  endtask

  task automatic check_all();
    chk("reg_cnt", reg_cnt, m_reg);
    chk("mem_cnt", mem_cnt, m_mem);
    chk("err_cnt", err_cnt, m_err);
    chk("fifo_count", fifo_count, q.size());
    chk("overflow", overflow, m_ovf);
    chk("rec_valid", rif.rec_valid, q.size() != 0);
    if (q.size() > 0) begin
      chk("rec_index", rif.rec_index, q[0].idx);
      chk("rec_type", rif.rec_type, q[0].ty);
      chk("rec_code", rif.rec_code, q[0].code);
    end
  endtask

  task automatic cycle(logic [1:0] ft, logic [3:0] ec, logic rdy,
                       bit do_chk = 1);
    format_type  = ft;
    error_code   = ec;
    rif.rec_ready = rdy;
    model_step(ft, ec, rdy);
    @(posedge clk);
    #1;
    if (do_chk) check_all();
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_reg"}, reg_cnt, 0);
    chk({tag, "_mem"}, mem_cnt, 0);
    chk({tag, "_err"}, err_cnt, 0);
    chk({tag, "_cnt"}, fifo_count, 0);
    chk({tag, "_ovf"}, overflow, 0);
    chk({tag, "_vld"}, rif.rec_valid, 0);
    chk({tag, "_idx"}, rif.rec_index, 0);
    chk({tag, "_typ"}, rif.rec_type, 0);
    chk({tag, "_cod"}, rif.rec_code, 0);
  endtask

  // Reset is raised between edges; outputs must clear before any edge.
  task automatic do_reset(string tag);
    #1;
    reset = 1'b1;
    #1;
    check_zero(tag);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    format_type = '0;
    error_code = '0;
    rif.rec_ready = 1'b0;
  endtask

  initial begin
    rif.rec_ready = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset("rst0");

    // three lines, only the memory line carries an error
    cycle(2'b01, 4'h0, 1'b1);
    cycle(2'b10, 4'h4, 1'b1);
    chk("t1_vld", rif.rec_valid, 1);
    chk("t1_idx", rif.rec_index, 1);
    chk("t1_typ", rif.rec_type, 2'b10);
    chk("t1_cod", rif.rec_code, 4'h4);
    cycle(2'b01, 4'h0, 1'b1);
    chk("t1_gone", rif.rec_valid, 0);
    chk("t1_reg", reg_cnt, 2);
    chk("t1_mem", mem_cnt, 1);
    chk("t1_err", err_cnt, 1);

    // overflow: five errors into a depth-4 FIFO
    do_reset("rst1");
    for (int i = 0; i < 5; i++) cycle(2'b01, 4'h1, 1'b0);
    chk("t2_cnt", fifo_count, 4);
    chk("t2_ovf", overflow, 1);
    chk("t2_err", err_cnt, 5);
    for (int i = 0; i < 4; i++) begin
      chk("t2_drain", rif.rec_index, i);
      cycle(2'b00, 4'h0, 1'b1);
    end
    chk("t2_empty", rif.rec_valid, 0);

    // full FIFO with simultaneous push and pop
    do_reset("rst2");
    for (int i = 0; i < 4; i++) cycle(2'b10, 4'h2, 1'b0);
    cycle(2'b01, 4'h8, 1'b1);
    chk("t3_cnt", fifo_count, 4);
    chk("t3_ovf", overflow, 0);
    for (int i = 0; i < 3; i++) cycle(2'b00, 4'h0, 1'b1);
    chk("t3_new", rif.rec_index, 4);
    chk("t3_newc", rif.rec_code, 4'h8);
    cycle(2'b00, 4'h0, 1'b1);

    // illegal format is invisible
    cycle(2'b11, 4'hF, 1'b0);
    chk("t4_cnt", fifo_count, 0);
    cycle(2'b10, 4'h1, 1'b0);
    chk("t4_idx", rif.rec_index, 5);

    // saturation and index wrap
    do_reset("rst3");
    for (int i = 0; i < 65540; i++) cycle(2'b01, 4'h0, 1'b0, i >= 65530);
    chk("t5_sat", reg_cnt, 16'hFFFF);
    cycle(2'b10, 4'h2, 1'b0);
    chk("t5_wrap", rif.rec_index, 4);

    // random traffic
    do_reset("rst4");
    for (int i = 0; i < 400; i++) begin
      logic [1:0] ft;
      logic [3:0] ec;
      ft = 2'($urandom_range(0, 3));
      ec = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      cycle(ft, ec, 1'($urandom_range(0, 2) == 0));
    end

    // reset mid-operation with two records queued and an error line in flight
    do_reset("rst5");
    cycle(2'b01, 4'h1, 1'b0);
    cycle(2'b10, 4'h3, 1'b0);
    chk("t6_cnt", fifo_count, 2);
    format_type = 2'b01;
    error_code  = 4'h2;
    rif.rec_ready = 1'b1;
    do_reset("t6_async");
    cycle(2'b01, 4'h0, 1'b0);
    chk("t6_reg", reg_cnt, 1);
    cycle(2'b10, 4'h4, 1'b0);
    cycle(2'b01, 4'h1, 1'b0);
    chk("t6_first", rif.rec_index, 1);
    do_reset("rst6");
    cycle(2'b10, 4'h4, 1'b0);
    chk("t6_idx0", rif.rec_index, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
